// File: rtl/fft_share_sched.sv
// Round-robin frame scheduler sharing one FFT core among NREQ requesters.
// Inverse frames: conjugate on input, conjugate and scale by 1/N on output.
module fft_share_sched #(
  parameter int WIDTH        = 32,
  parameter int NREQ         = 3,
  parameter int FFT_N        = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_inv,
  input  logic [NREQ*WIDTH-1:0]     req_re,
  input  logic [NREQ*WIDTH-1:0]     req_im,
  output logic [NREQ-1:0]           req_ready,
  output logic                      core_in_en,
  output logic [WIDTH-1:0]          core_in_re,
  output logic [WIDTH-1:0]          core_in_im,
  input  logic                      core_out_en,
  input  logic [WIDTH-1:0]          core_out_re,
  input  logic [WIDTH-1:0]          core_out_im,
  output logic                      out_en,
  output logic [WIDTH-1:0]          out_re,
  output logic [WIDTH-1:0]          out_im,
  output logic [$clog2(NREQ)-1:0]   out_tag,
  output logic                      out_last,
  output logic                      err_underrun,
  output logic                      err_orphan
);

  localparam int LOG2N = $clog2(FFT_N);
  localparam int CW    = (LOG2N > 0) ? LOG2N : 1;
  localparam int TW    = $clog2(NREQ);
  localparam int FW    = $clog2(MAX_INFLIGHT + 1);
  localparam int PW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CW-1:0] LAST = CW'(FFT_N - 1);

  typedef enum logic {IDLE, FEED} state_t;

  typedef struct packed {
    logic [TW-1:0] idx;
    logic          inv;
  } tag_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   idx_q, idx_d;
  logic            inv_q, inv_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [TW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] ready_q, ready_d;

  logic             cin_en_q, cin_en_d;
  logic [WIDTH-1:0] cin_re_q, cin_re_d;
  logic [WIDTH-1:0] cin_im_q, cin_im_d;
  logic             underrun_q, underrun_d;

  tag_t            fifo_q [MAX_INFLIGHT];
  tag_t            fifo_d [MAX_INFLIGHT];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [FW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;

  logic             oen_q, oen_d;
  logic [WIDTH-1:0] ore_q, ore_d;
  logic [WIDTH-1:0] oim_q, oim_d;
  logic [TW-1:0]    otag_q, otag_d;
  logic             olast_q, olast_d;
  logic             orphan_q, orphan_d;

  logic                    gnt_ok;
  logic [TW-1:0]           gnt_idx;
  logic [TW-1:0]           cand;
  logic                    last_in;
  logic                    has_tag;
  logic                    pop;
  logic                    room;
  logic                    grant;
  logic                    cur_valid;
  logic [WIDTH-1:0]        s_re;
  logic [WIDTH-1:0]        s_im;
  tag_t                    head;
  logic signed [WIDTH-1:0] sh_re;
  logic signed [WIDTH-1:0] sh_im;

  // Search from rr_q; at end of frame the current owner yields to others.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = TW'((int'(rr_q) + k) % NREQ);
      if (req_valid[cand] && !(state_q == FEED && cand == idx_q)) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign has_tag = (count_q != '0);
  assign head    = fifo_q[rptr_q];
  assign pop     = core_out_en && has_tag && (out_cnt_q == LAST);
  assign room    = (count_q < FW'(MAX_INFLIGHT)) || pop;
  assign last_in = (state_q == FEED) && (in_cnt_q == LAST);
  assign grant   = room && gnt_ok && ((state_q == IDLE) || last_in);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    inv_d    = inv_q;
    in_cnt_d = in_cnt_q;
    rr_d     = rr_q;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = FEED;
      end
      FEED: begin
        in_cnt_d = in_cnt_q + 1'b1;
        if (last_in) begin
          in_cnt_d = '0;
          state_d  = grant ? FEED : IDLE;
        end
      end
    endcase
    if (grant) begin
      idx_d = gnt_idx;
      inv_d = req_inv[gnt_idx];
      rr_d  = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    ready_d = (state_d == FEED) ? (NREQ'(1) << idx_d) : '0;
  end

  assign cur_valid = req_valid[idx_q];
  assign s_re      = req_re[int'(idx_q)*WIDTH +: WIDTH];
  assign s_im      = req_im[int'(idx_q)*WIDTH +: WIDTH];

  always_comb begin
    cin_en_d   = (state_q == FEED);
    cin_re_d   = '0;
    cin_im_d   = '0;
    underrun_d = underrun_q;
    if (state_q == FEED) begin
      if (cur_valid) begin
        cin_re_d = s_re;
        cin_im_d = inv_q ? -s_im : s_im;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + FW'(grant) - FW'(pop);
    if (grant) begin
      fifo_d[wptr_q] = '{idx: gnt_idx, inv: req_inv[gnt_idx]};
      wptr_d = (wptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  assign sh_re = $signed(core_out_re) >>> LOG2N;
  assign sh_im = $signed(core_out_im) >>> LOG2N;

  // Orphan samples pass through untagged and do not advance out_cnt.
  always_comb begin
    oen_d     = core_out_en;
    ore_d     = '0;
    oim_d     = '0;
    otag_d    = '0;
    olast_d   = 1'b0;
    out_cnt_d = out_cnt_q;
    orphan_d  = orphan_q;
    if (core_out_en) begin
      ore_d = core_out_re;
      oim_d = core_out_im;
      if (has_tag) begin
        otag_d    = head.idx;
        olast_d   = (out_cnt_q == LAST);
        out_cnt_d = olast_d ? '0 : out_cnt_q + 1'b1;
        if (head.inv) begin
          ore_d = sh_re;
          oim_d = -sh_im;
        end
      end else begin
        orphan_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      inv_q      <= 1'b0;
      in_cnt_q   <= '0;
      rr_q       <= '0;
      ready_q    <= '0;
      cin_en_q   <= 1'b0;
      cin_re_q   <= '0;
      cin_im_q   <= '0;
      underrun_q <= 1'b0;
      fifo_q     <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      oen_q      <= 1'b0;
      ore_q      <= '0;
      oim_q      <= '0;
      otag_q     <= '0;
      olast_q    <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      inv_q      <= inv_d;
      in_cnt_q   <= in_cnt_d;
      rr_q       <= rr_d;
      ready_q    <= ready_d;
      cin_en_q   <= cin_en_d;
      cin_re_q   <= cin_re_d;
      cin_im_q   <= cin_im_d;
      underrun_q <= underrun_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      oen_q      <= oen_d;
      ore_q      <= ore_d;
      oim_q      <= oim_d;
      otag_q     <= otag_d;
      olast_q    <= olast_d;
      orphan_q   <= orphan_d;
    end
  end

  assign req_ready    = ready_q;
  assign core_in_en   = cin_en_q;
  assign core_in_re   = cin_re_q;
  assign core_in_im   = cin_im_q;
  assign out_en       = oen_q;
  assign out_re       = ore_q;
  assign out_im       = oim_q;
  assign out_tag      = otag_q;
  assign out_last     = olast_q;
  assign err_underrun = underrun_q;
  assign err_orphan   = orphan_q;

endmodule

// File: tb/tb_fft_share_sched.sv
// Directed bench for fft_share_sched: requester frame sources, a scripted
// core output, and per-scenario tasks with hand-computed expectations.
module tb_fft_share_sched;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int FN = 64;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_inv;
  logic [N*W-1:0]    req_re;
  logic [N*W-1:0]    req_im;
  logic [N-1:0]      req_ready;
  logic              core_in_en;
  logic [W-1:0]      core_in_re;
  logic [W-1:0]      core_in_im;
  logic              core_out_en;
  logic [W-1:0]      core_out_re;
  logic [W-1:0]      core_out_im;
  logic              out_en;
  logic [W-1:0]      out_re;
  logic [W-1:0]      out_im;
  logic [1:0]        out_tag;
  logic              out_last;
  logic              err_underrun;
  logic              err_orphan;

  int n_tests;
  int n_fail;

  fft_share_sched #(
    .WIDTH(W), .NREQ(N), .FFT_N(FN), .MAX_INFLIGHT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_inv(req_inv),
    .req_re(req_re), .req_im(req_im),
    .req_ready(req_ready),
    .core_in_en(core_in_en), .core_in_re(core_in_re),
    .core_in_im(core_in_im),
    .core_out_en(core_out_en), .core_out_re(core_out_re),
    .core_out_im(core_out_im),
    .out_en(out_en), .out_re(out_re), .out_im(out_im),
    .out_tag(out_tag), .out_last(out_last),
    .err_underrun(err_underrun), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester sources: sample advances whenever the DUT consumes it.
  logic [W-1:0] src_re [N][FN];
  logic [W-1:0] src_im [N][FN];
  int           scnt [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) scnt[i] <= 0;
      else if (req_ready[i]) scnt[i] <= (scnt[i] + 1) % FN;
    end
  end

  always_comb begin
    req_re = '0;
    req_im = '0;
    for (int i = 0; i < N; i++) begin
      req_re[i*W +: W] = src_re[i][scnt[i]];
      req_im[i*W +: W] = src_im[i][scnt[i]];
    end
  end

  logic [W-1:0] cin_re [$];
  logic [W-1:0] cin_im [$];
  logic [W-1:0] o_re [$];
  logic [W-1:0] o_im [$];
  logic [1:0]   o_tag [$];
  logic         o_last [$];

  always @(negedge clk) begin
    if (core_in_en) begin
      cin_re.push_back(core_in_re);
      cin_im.push_back(core_in_im);
    end
    if (out_en) begin
      o_re.push_back(out_re);
      o_im.push_back(out_im);
      o_tag.push_back(out_tag);
      o_last.push_back(out_last);
    end
  end

  logic [W-1:0] cre [FN];
  logic [W-1:0] cim [FN];

  task automatic clear_logs();
    cin_re.delete(); cin_im.delete();
    o_re.delete(); o_im.delete();
    o_tag.delete(); o_last.delete();
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < FN; k++) begin
        src_re[i][k] = '0;
        src_im[i][k] = '0;
      end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic emit_frame();
    for (int k = 0; k < FN; k++) begin
      @(posedge clk); #1;
      core_out_en = 1'b1;
      core_out_re = cre[k];
      core_out_im = cim[k];
    end
    @(posedge clk); #1;
    core_out_en = 1'b0;
    core_out_re = '0;
    core_out_im = '0;
  endtask

  task automatic drive_frame(input int i, input bit inv, input int drop_at);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    req_inv[i]   = inv;
    req_valid[i] = 1'b1;
    while (seen < FN && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (req_ready[i]) begin
        seen++;
        if (seen == drop_at) begin
          @(posedge clk); #1;
          req_valid[i] = 1'b0;
          @(negedge clk);
          cyc++;
          if (req_ready[i]) seen++;
          @(posedge clk); #1;
          req_valid[i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_inv[i]   = 1'b0;
    n_tests++;
    if (seen != FN) begin
      n_fail++;
      $display("FAIL drive_frame%0d: ready cycles %0d, expected %0d", i, seen, FN);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready, core_in_en, core_in_re, core_in_im} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: ready=%b en=%b re=%h im=%h, expected all 0",
               req_ready, core_in_en, core_in_re, core_in_im);
    end
    n_tests++;
    if ({out_en, out_re, out_im, out_tag, out_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: en=%b re=%h im=%h tag=%0d last=%b, expected all 0",
               out_en, out_re, out_im, out_tag, out_last);
    end
    n_tests++;
    if ({err_underrun, err_orphan} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err: got %b%b, expected 00", err_underrun, err_orphan);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_orphan();
    core_out_en = 1'b1;
    core_out_re = 32'h0000_0005;
    core_out_im = 32'hFFFF_FFF9;
    @(posedge clk); #1;
    core_out_en = 1'b0;
    core_out_re = '0;
    core_out_im = '0;
    @(negedge clk);
    n_tests++;
    if ({out_en, out_re, out_im} !== {1'b1, 32'h0000_0005, 32'hFFFF_FFF9}) begin
      n_fail++;
      $display("FAIL orphan_data: en=%b re=%h im=%h, expected 1 00000005 fffffff9",
               out_en, out_re, out_im);
    end
    n_tests++;
    if ({out_tag, out_last} !== 3'b000) begin
      n_fail++;
      $display("FAIL orphan_tag: tag=%0d last=%b, expected 0 0", out_tag, out_last);
    end
    @(negedge clk);
    n_tests++;
    if ({out_en, err_orphan} !== 2'b01) begin
      n_fail++;
      $display("FAIL orphan_sticky: en=%b err=%b, expected 0 1", out_en, err_orphan);
    end
    apply_reset();
  endtask

  task automatic test_forward();
    int bad;
    int nl;
    clear_src();
    clear_logs();
    src_re[0][0] = 32'h0100_0000;
    drive_frame(0, 1'b0, -1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cin_re.size() != FN) begin
      n_fail++;
      $display("FAIL fwd_in_len: %0d core_in samples, expected %0d", cin_re.size(), FN);
    end
    bad = 0;
    for (int k = 0; k < cin_re.size(); k++) begin
      if (cin_re[k] !== ((k == 0) ? 32'h0100_0000 : 32'h0)) bad++;
      if (cin_im[k] !== 32'h0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fwd_in_data: %0d wrong core_in words, expected 0", bad);
    end
    for (int k = 0; k < FN; k++) begin
      cre[k] = 32'h0100_0000;
      cim[k] = '0;
    end
    emit_frame();
    repeat (3) @(negedge clk);
    n_tests++;
    if (o_re.size() != FN) begin
      n_fail++;
      $display("FAIL fwd_out_len: %0d outputs, expected %0d", o_re.size(), FN);
    end
    bad = 0;
    nl  = 0;
    for (int k = 0; k < o_re.size(); k++) begin
      if (o_re[k] !== 32'h0100_0000 || o_im[k] !== 32'h0) bad++;
      if (o_tag[k] !== 2'd0) bad++;
      if (o_last[k]) nl++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fwd_out_data: %0d wrong outputs, expected 0", bad);
    end
    n_tests++;
    if (nl != 1 || o_last.size() != FN || o_last[FN-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_last: %0d last flags, expected one at sample 63", nl);
    end
    n_tests++;
    if ({err_underrun, err_orphan} !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_err: got %b%b, expected 00", err_underrun, err_orphan);
    end
  endtask

  task automatic test_inverse();
    int bad;
    logic [W-1:0] e_re;
    logic [W-1:0] e_im;
    clear_src();
    clear_logs();
    for (int k = 0; k < FN; k++) src_re[1][k] = 32'h0100_0000;
    src_im[1][5] = 32'h8000_0000;
    src_im[1][6] = 32'h0000_0001;
    src_im[1][7] = 32'h0000_0010;
    drive_frame(1, 1'b1, -1);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int k = 0; k < cin_re.size(); k++) begin
      e_im = (k == 5) ? 32'h8000_0000 :
             (k == 6) ? 32'hFFFF_FFFF :
             (k == 7) ? 32'hFFFF_FFF0 : 32'h0;
      if (cin_re[k] !== 32'h0100_0000 || cin_im[k] !== e_im) bad++;
    end
    n_tests++;
    if (bad != 0 || cin_re.size() != FN) begin
      n_fail++;
      $display("FAIL inv_in_conj: %0d wrong of %0d words, expected 0 of 64",
               bad, cin_re.size());
    end
    for (int k = 0; k < FN; k++) begin
      cre[k] = '0;
      cim[k] = '0;
    end
    cre[0] = 32'h4000_0000;
    cre[2] = 32'hFFFF_FFC0;
    cim[1] = 32'h0000_0640;
    cim[3] = 32'hFFFF_F000;
    emit_frame();
    repeat (3) @(negedge clk);
    n_tests++;
    if (o_re.size() != FN) begin
      n_fail++;
      $display("FAIL inv_out_len: %0d outputs, expected %0d", o_re.size(), FN);
    end else begin
      n_tests++;
      if (o_re[0] !== 32'h0100_0000) begin
        n_fail++;
        $display("FAIL inv_scale: out[0].re=%h, expected 01000000", o_re[0]);
      end
      bad = 0;
      for (int k = 0; k < FN; k++) begin
        e_re = (k == 0) ? 32'h0100_0000 : (k == 2) ? 32'hFFFF_FFFF : 32'h0;
        e_im = (k == 1) ? 32'hFFFF_FFE7 : (k == 3) ? 32'h0000_0040 : 32'h0;
        if (o_re[k] !== e_re || o_im[k] !== e_im) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL inv_out_data: %0d wrong outputs, expected 0", bad);
      end
      bad = 0;
      for (int k = 0; k < FN; k++) begin
        if (o_tag[k] !== 2'd1) bad++;
        if (o_last[k] !== (k == FN - 1)) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL inv_tag_last: %0d wrong tag/last, expected tag 1 last at 63", bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rv [200];
    logic         ce [200];
    logic [W-1:0] cr [200];
    int f;
    int bad;
    int bad_en;
    int bad_d;
    apply_reset();
    clear_src();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < FN; k++) src_re[i][k] = W'((i + 1) * 256 + k);
    req_inv   = '0;
    req_valid = 3'b111;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rv[c] = req_ready;
      ce[c] = core_in_en;
      cr[c] = core_in_re;
    end
    f = -1;
    for (int c = 0; c < 200; c++) if (f < 0 && rv[c] != '0) f = c;
    n_tests++;
    if (f != 1) begin
      n_fail++;
      $display("FAIL b2b_grant: first ready at cycle %0d, expected 1", f);
    end else begin
      bad = 0;
      bad_en = 0;
      bad_d = 0;
      for (int j = 0; j < 2 * FN; j++) begin
        if (rv[f+j] !== ((j < FN) ? 3'b001 : 3'b010)) bad++;
        if (ce[f+1+j] !== 1'b1) bad_en++;
        if (cr[f+1+j] !== ((j < FN) ? W'(256 + j) : W'(512 + j - FN))) bad_d++;
      end
      if (rv[f+2*FN] !== 3'b000) bad++;
      if (ce[f+1+2*FN] !== 1'b0) bad_en++;
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL b2b_ready: %0d wrong ready cycles, expected 0", bad);
      end
      n_tests++;
      if (bad_en != 0) begin
        n_fail++;
        $display("FAIL b2b_en: %0d wrong core_in_en cycles, expected 0", bad_en);
      end
      n_tests++;
      if (bad_d != 0) begin
        n_fail++;
        $display("FAIL b2b_data: %0d wrong core_in words, expected 0", bad_d);
      end
    end
  endtask

  task automatic test_inflight_limit();
    int last_c;
    int g_c;
    logic [1:0] tag_l;
    last_c = -1;
    g_c    = -1;
    tag_l  = 2'd3;
    n_tests++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL limit_wait: ready=%b with 2 in flight, expected 000", req_ready);
    end
    for (int k = 0; k < FN; k++) begin
      cre[k] = '0;
      cim[k] = '0;
    end
    fork
      emit_frame();
      begin
        for (int c = 0; c < 120; c++) begin
          @(negedge clk);
          if (last_c < 0 && out_last) begin
            last_c = c;
            tag_l  = out_tag;
          end
          if (g_c < 0 && req_ready[2]) g_c = c;
        end
      end
    join
    n_tests++;
    if (last_c < 0) begin
      n_fail++;
      $display("FAIL limit_last: no out_last seen, expected one");
    end
    n_tests++;
    if (g_c != last_c || g_c < 0) begin
      n_fail++;
      $display("FAIL limit_grant: req2 ready at cycle %0d, expected %0d", g_c, last_c);
    end
    n_tests++;
    if (tag_l !== 2'd0) begin
      n_fail++;
      $display("FAIL limit_tag: first frame tag %0d, expected 0", tag_l);
    end
    req_valid = '0;
    apply_reset();
  endtask

  task automatic test_underrun();
    clear_src();
    clear_logs();
    for (int k = 0; k < FN; k++) src_re[0][k] = W'(k + 1);
    drive_frame(0, 1'b0, 10);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cin_re.size() != FN) begin
      n_fail++;
      $display("FAIL und_len: %0d core_in samples, expected %0d", cin_re.size(), FN);
    end else begin
      n_tests++;
      if (cin_re[10] !== 32'h0 || cin_im[10] !== 32'h0) begin
        n_fail++;
        $display("FAIL und_zero: sample10 %h/%h, expected 0/0", cin_re[10], cin_im[10]);
      end
      n_tests++;
      if (cin_re[9] !== 32'd10 || cin_re[11] !== 32'd12 || cin_re[63] !== 32'd64) begin
        n_fail++;
        $display("FAIL und_data: s9=%0d s11=%0d s63=%0d, expected 10 12 64",
                 cin_re[9], cin_re[11], cin_re[63]);
      end
    end
    n_tests++;
    if (err_underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL und_flag: err_underrun=%b, expected 1", err_underrun);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    req_valid[0] = 1'b1;
    while (seen < 30 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready[0]) seen++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, core_in_en, out_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL rmid_out: ready=%b in_en=%b out_en=%b, expected 0",
               req_ready, core_in_en, out_en);
    end
    n_tests++;
    if ({err_underrun, err_orphan} !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_err: got %b%b, expected 00", err_underrun, err_orphan);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL rmid_rr: ready=%b after reset, expected 001", req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (core_in_en !== 1'b1 || core_in_re !== 32'd1) begin
      n_fail++;
      $display("FAIL rmid_restart: en=%b re=%h, expected 1 00000001",
               core_in_en, core_in_re);
    end
    req_valid = '0;
    apply_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    req_valid   = '0;
    req_inv     = '0;
    core_out_en = 1'b0;
    core_out_re = '0;
    core_out_im = '0;
    clear_src();
    test_reset();
    test_orphan();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_inflight_limit();
    test_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
